// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI frame sequencer.
// Holds the sequencer state encoding, the TX FIFO word layout
// ({last, data}) and a small helper for sizing the CS timing counter.
package spi_seq_pkg;

  // Sequencer states, from chip-select assertion through the inter-frame gap
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT_RX,
    WAIT_RDY,
    STALL,
    HOLD,
    GAP
  } seq_state_e;

  // TX FIFO entries carry the frame-closing flag above the data byte
  localparam int TX_W     = 9;
  localparam int LAST_BIT = 8;

  // Largest of the three CS timing values, used to size the shared counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_frame_sequencer_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset, empties the FIFO
//   push_i  - write wdata_i this cycle (caller guarantees space, or a
//             simultaneous pop when full)
//   pop_i   - drop the head entry this cycle (ignored when empty)
//   wdata_i - write data
//   rdata_o - head entry, valid whenever empty_o is low
//   full_o  - no free entries
//   empty_o - no stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             popOk;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // when the index bits coincide.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign popOk   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  // Pointer bookkeeping; a push while full is only legal alongside a pop,
  // in which case the head is read out before its slot is overwritten.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: stream front end for a byte-level SPI master.
// Buffers outgoing bytes, issues them one at a time to the master over
// its TX_DV/TX_READY handshake, collects returned bytes, and drives chip
// select with programmable setup, hold and inter-frame gap.
// Ports:
//   PCLK, PRESET       - clock and asynchronous active-high reset
//   IN_DATA/IN_VALID/IN_LAST/IN_READY  - outgoing byte stream, LAST closes a frame
//   OUT_DATA/OUT_VALID/OUT_READY       - received byte stream
//   M_DATA_BYTE_IN/M_TX_DV/M_TX_READY  - byte issue handshake to the master
//   M_RX_DV/M_DATA_BYTE_OUT            - received byte from the master
//   SPI_CSN            - chip select, active low
//   BUSY               - sequencer not idle
//   RX_OVF/RX_OVF_CLR  - sticky receive-overflow flag and its clear
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [7:0] IN_DATA,
  input  logic       IN_VALID,
  input  logic       IN_LAST,
  output logic       IN_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] M_DATA_BYTE_IN,
  output logic       M_TX_DV,
  input  logic       M_TX_READY,
  input  logic       M_RX_DV,
  input  logic [7:0] M_DATA_BYTE_OUT,
  output logic       SPI_CSN,
  output logic       BUSY,
  output logic       RX_OVF,
  input  logic       RX_OVF_CLR
);

  localparam int CNT_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             csn_q;
  logic             txDv_q;
  logic [7:0]       dataByte_q;
  logic             last_q;
  logic             rxOvf_q;
  logic             rxOvf_d;

  logic [TX_W-1:0]  txHead;
  logic             txFull;
  logic             txEmpty;
  logic             txPush;
  logic             txPop;

  logic [7:0]       rxHead;
  logic             rxFull;
  logic             rxEmpty;
  logic             rxPush;
  logic             rxPop;
  logic             rxDrop;

  // TX side refuses pushes whenever full, even if the head leaves this cycle.
  assign IN_READY = !txFull;
  assign txPush   = IN_VALID && !txFull;
  assign txPop    = (state_q == ISSUE) && M_TX_READY;

  // RX side accepts a byte into a full FIFO only when the head drains together.
  assign OUT_VALID = !rxEmpty;
  assign OUT_DATA  = rxHead;
  assign rxPop     = !rxEmpty && OUT_READY;
  assign rxPush    = M_RX_DV && (!rxFull || rxPop);
  assign rxDrop    = M_RX_DV && rxFull && !rxPop;

  sync_fifo #(
    .WIDTH (TX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_txFifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (txPush),
    .pop_i   (txPop),
    .wdata_i ({IN_LAST, IN_DATA}),
    .rdata_o (txHead),
    .full_o  (txFull),
    .empty_o (txEmpty)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rxFifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (rxPush),
    .pop_i   (rxPop),
    .wdata_i (M_DATA_BYTE_OUT),
    .rdata_o (rxHead),
    .full_o  (rxFull),
    .empty_o (rxEmpty)
  );

  // Overflow is sticky; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    rxOvf_d = rxOvf_q;
    if (RX_OVF_CLR) rxOvf_d = 1'b0;
    if (rxDrop)     rxOvf_d = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) rxOvf_q <= 1'b0;
    else        rxOvf_q <= rxOvf_d;
  end

  // Frame sequencer: owns chip select and the byte issue handshake.
  // The timing counter is cleared by default so every state entry starts
  // from zero; SETUP, HOLD and GAP each last exactly their programmed count.
  // M_TX_DV is a registered one-cycle pulse following the ISSUE cycle in
  // which the master reported ready.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      csn_q      <= 1'b1;
      txDv_q     <= 1'b0;
      dataByte_q <= '0;
      last_q     <= 1'b0;
    end else begin
      txDv_q <= 1'b0;
      cnt_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (!txEmpty) begin
            state_q <= SETUP;
            csn_q   <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) state_q <= ISSUE;
          else                     cnt_q   <= cnt_q + CNT_W'(1);
        end
        ISSUE: begin
          if (M_TX_READY) begin
            txDv_q     <= 1'b1;
            dataByte_q <= txHead[7:0];
            last_q     <= txHead[LAST_BIT];
            state_q    <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (M_RX_DV) state_q <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (M_TX_READY) begin
            if (last_q)        state_q <= HOLD;
            else if (!txEmpty) state_q <= ISSUE;
            else               state_q <= STALL;
          end
        end
        STALL: begin
          if (!txEmpty) state_q <= ISSUE;
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= GAP;
            csn_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) state_q <= IDLE;
          else                   cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: begin
          state_q <= IDLE;
          csn_q   <= 1'b1;
        end
      endcase
    end
  end

  assign SPI_CSN        = csn_q;
  assign M_TX_DV        = txDv_q;
  assign M_DATA_BYTE_IN = dataByte_q;
  assign BUSY           = (state_q != IDLE);
  assign RX_OVF         = rxOvf_q;

endmodule
